vram_fetch: RTL

- Read-side initiator for one port of the shared dual-port video/system RAM (byte-wide, registered read, 1-cycle latency, ce/we/a/di/do port).
- On a start pulse, fetches `count` character/attribute byte pairs from consecutive addresses and delivers them as 16-bit tokens through a small ready/valid FIFO to the pixel/scan-out pipeline.
- Sustains one pair every 2 clocks; throttles RAM reads so the FIFO never overflows.

---
 rtl/vram_fetch_pkg.sv | 21 ++
 rtl/vram_fetch_if.sv | 39 +++
 rtl/vram_fetch_fifo_sync.sv | 68 ++++++
 rtl/vram_fetch.sv | 128 ++++++++++++
 4 files changed

// File: rtl/vram_fetch_pkg.sv
// ----------------------------------------------------------------------------
// Package : vram_fetch_pkg
// Shared FSM state encoding and pair width for the VRAM fetch block.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vram_fetch_pkg;

   localparam int unsigned c_pair_w = 16;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t c_st_idle  = 2'd0;
   localparam fetch_state_t c_st_char  = 2'd1;
   localparam fetch_state_t c_st_attr  = 2'd2;
   localparam fetch_state_t c_st_drain = 2'd3;

endpackage

`default_nettype wire

// File: rtl/vram_fetch_if.sv
// ----------------------------------------------------------------------------
// Interface : vram_fetch_if
// Run control, RAM port and output pair stream of the VRAM fetch block.
// Rev       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface vram_fetch_if #(
   parameter int AW = 14
);
   logic          start;
   logic [AW-1:0] base_addr;
   logic [7:0]    count;
   logic          busy;
   logic          done;
   logic          ram_ce;
   logic          ram_we;
   logic [7:0]    ram_di;
   logic [AW-1:0] ram_a;
   logic [7:0]    ram_do;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_char;
   logic [7:0]    out_attr;

   modport master (
      input  start, base_addr, count, ram_do, out_ready,
      output busy, done, ram_ce, ram_we, ram_di, ram_a,
             out_valid, out_char, out_attr
   );

   modport slave (
      output start, base_addr, count, ram_do, out_ready,
      input  busy, done, ram_ce, ram_we, ram_di, ram_a,
             out_valid, out_char, out_attr
   );
endinterface

`default_nettype wire

// File: rtl/vram_fetch_fifo_sync.sv
// ----------------------------------------------------------------------------
// Module : vram_fetch_fifo_sync
// Synchronous first-word fall-through FIFO; head reads as zero when empty.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vram_fetch_fifo_sync #(
   parameter int WIDTH      = 16,
   parameter int LOG2_DEPTH = 2
) (
   input  wire logic                  clock,
   input  wire logic                  reset,
   input  wire logic                  push,
   input  wire logic [WIDTH-1:0]      din,
   input  wire logic                  pop,
   output logic      [WIDTH-1:0]      dout,
   output logic                       full,
   output logic                       empty,
   output logic      [LOG2_DEPTH:0]   count
);

   localparam logic [LOG2_DEPTH:0] c_depth = (LOG2_DEPTH+1)'(2**LOG2_DEPTH);

   logic [WIDTH-1:0]      r_mem [2**LOG2_DEPTH];
   logic [LOG2_DEPTH-1:0] r_wr_ptr;
   logic [LOG2_DEPTH-1:0] r_rd_ptr;
   logic [LOG2_DEPTH:0]   r_count;
   logic                  w_wr;
   logic                  w_rd;

   assign full  = (r_count == c_depth);
   assign empty = (r_count == '0);
   assign count = r_count;
   assign w_rd  = pop && !empty;
   // A pop in the same cycle makes room, so a push into a full FIFO is still safe.
   assign w_wr  = push && (!full || w_rd);
   assign dout  = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clock) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + LOG2_DEPTH'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + LOG2_DEPTH'(1);
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (LOG2_DEPTH+1)'(1);
            2'b01:   r_count <= r_count - (LOG2_DEPTH+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/vram_fetch.sv
// ----------------------------------------------------------------------------
// Module : vram_fetch
// Reads char/attr byte pairs from video RAM into a ready/valid output FIFO.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vram_fetch
   import vram_fetch_pkg::*;
#(
   parameter int AW = 14,
   parameter int FD = 2
) (
   input wire logic     clock,
   input wire logic     reset,
   vram_fetch_if.master bus
);

   fetch_state_t  r_state;
   fetch_state_t  w_next_state;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] r_a_hold;
   logic [7:0]    r_rem;
   logic [7:0]    r_char_hold;
   logic          r_land;
   logic          r_done;
   logic          w_issue_ok;
   logic          w_ce;
   logic          w_busy;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [FD:0]   w_occ;
   logic [c_pair_w-1:0] w_head;

   localparam logic [FD:0] c_last_slot = (FD+1)'(2**FD - 1);

   // A pair landing this cycle already claims a slot, so leave one more free.
   assign w_issue_ok = r_land ? (w_occ < c_last_slot) : !w_full;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle:  if (bus.start && (bus.count != 8'd0)) w_next_state = c_st_char;
         c_st_char:  if (w_issue_ok) w_next_state = c_st_attr;
         c_st_attr:  w_next_state = (r_rem == 8'd1) ? c_st_drain : c_st_char;
         c_st_drain: w_next_state = c_st_idle;
         default:    w_next_state = c_st_idle;
      endcase
   end

   always_comb begin
      w_ce   = 1'b0;
      w_busy = 1'b1;
      case (r_state)
         c_st_idle:  w_busy = 1'b0;
         c_st_char:  w_ce   = w_issue_ok;
         c_st_attr:  w_ce   = 1'b1;
         default:    w_ce   = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_addr      <= '0;
         r_a_hold    <= '0;
         r_rem       <= '0;
         r_char_hold <= '0;
         r_land      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_land <= (r_state == c_st_attr);
         r_done <= (r_state == c_st_drain) ||
                   ((r_state == c_st_idle) && bus.start && (bus.count == 8'd0));
         if ((r_state == c_st_idle) && bus.start) begin
            r_addr <= bus.base_addr;
            r_rem  <= bus.count;
         end else if (w_ce) begin
            r_addr <= r_addr + AW'(1);
         end
         if (w_ce) begin
            r_a_hold <= r_addr;
         end
         if (r_state == c_st_attr) begin
            r_char_hold <= bus.ram_do;
            r_rem       <= r_rem - 8'd1;
         end
      end
   end

   assign w_pop = !w_empty && bus.out_ready;

   vram_fetch_fifo_sync #(
      .WIDTH      (c_pair_w),
      .LOG2_DEPTH (FD)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (r_land),
      .din   ({r_char_hold, bus.ram_do}),
      .pop   (w_pop),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_occ)
   );

   assign bus.busy      = w_busy;
   assign bus.done      = r_done;
   assign bus.ram_ce    = w_ce;
   assign bus.ram_we    = 1'b0;
   assign bus.ram_di    = 8'd0;
   assign bus.ram_a     = w_ce ? r_addr : r_a_hold;
   assign bus.out_valid = !w_empty;
   assign bus.out_char  = w_head[15:8];
   assign bus.out_attr  = w_head[7:0];

endmodule

`default_nettype wire
